cmp_arb: RTL
============

Name: cmp_arb

Overview:
- Shares one W-bit signed comparator among N requesters.
- Round-robin arbitration over valid/ready request channels.
- Registers the compare result (eq/gt/lt), tagged with the winning requester id, into a single-entry output stage with valid/ready backpressure.
- Sits between pipeline clients, e.g. issue-side branch-condition evaluators, and a single shared compare datapath.

Parameters:
- N, 4, number of requesters; N >= 1.
- W, 32, operand width in bits; operands are two's-complement signed.
- IDW, (N > 1) ? $clog2(N) : 1, requester id width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst  input  1  asynchronous, active-high reset.
- i_req_vld  input  N  per-requester request valid.
- i_req_a  input  N*W  operand A; requester k occupies bits [k*W +: W].
- i_req_b  input  N*W  operand B; same packing as i_req_a.
- o_req_rdy  output  N  per-requester accept; at most one bit set per cycle.
- o_rsp_vld  output  1  response valid.
- o_rsp_id  output  IDW  index of the requester that produced the response.
- o_rsp_eq  output  1  A == B (signed).
- o_rsp_gt  output  1  A > B (signed).
- o_rsp_lt  output  1  A < B (signed).
- i_rsp_rdy  input  1  consumer accepts the response.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: o_rsp_vld=0, o_rsp_id=0, o_rsp_eq/gt/lt=0, round-robin pointer ptr=0. o_req_rdy is combinational and is 0 while arst is high.
- Output stage states: EMPTY (o_rsp_vld=0) and FULL (o_rsp_vld=1).
- accept_ok = !o_rsp_vld | i_rsp_rdy (single entry, drain-and-refill in the same cycle is allowed).
- Arbitration (combinational):
  - Search i_req_vld starting at index ptr, ascending, wrapping modulo N.
  - The first set bit g wins.
  - o_req_rdy[g] = accept_ok. All other o_req_rdy bits are 0.
  - No valid request, or accept_ok=0: o_req_rdy = 0.
- A transfer on requester k happens when i_req_vld[k] & o_req_rdy[k] on a clock edge. On that edge:
  - o_rsp_vld <= 1 and o_rsp_id <= k.
  - eq/gt/lt <= signed compare of the operands of requester k.
  - ptr <= (k+1) mod N.
- Latency: a request accepted at edge t is visible on the outputs after edge t; exactly 1 cycle.
- No accept and (o_rsp_vld & i_rsp_rdy): o_rsp_vld <= 0. id and flags hold their last values (don't-care while invalid).
- FULL and i_rsp_rdy=0: all response outputs stay stable; no requester is granted; ptr holds.
- ptr changes only on an accept. An idle cycle never rotates priority.
- Exactly one of eq/gt/lt is 1 whenever o_rsp_vld=1.
- Compare is signed at full width W, no truncation.
  - Example, W=8: 8'h80 (-128) < 8'h7F (+127).
  - Example, W=8: 8'hFF (-1) > 8'hFE (-2).
- Requester rules:
  - It must hold vld and operands stable until accepted.
  - Dropping vld before it is accepted is legal; that requester simply loses.
- The arbiter samples operands only in the accept cycle.
- N=1: ptr stays 0; the block behaves as a 1-entry pipelined compare with o_rsp_id=0.
- arst asserted mid-operation:
  - Any pending response is discarded immediately (o_rsp_vld=0 asynchronously).
  - ptr returns to 0.
  - No request is accepted while arst is high.
- Assertions:
  - o_req_rdy is one-hot-or-zero.
  - Response outputs are stable while o_rsp_vld & !i_rsp_rdy.
  - eq/gt/lt are one-hot when o_rsp_vld=1.

Test Plan:
- Reset then idle, N=4 W=8: after arst deasserts, o_rsp_vld=0 and o_req_rdy=0 for 10 cycles; ptr stays 0.
- Single request, requester 2, a=8'h80 b=8'h7F, i_rsp_rdy=1: o_req_rdy=4'b0100 that cycle; next cycle o_rsp_vld=1, id=2, lt=1, eq=0, gt=0.
- All 4 requesters valid continuously, i_rsp_rdy=1: grants in order 0,1,2,3,0 on consecutive cycles; one response per cycle carrying ids 0,1,2,3,0.
- Backpressure:
  - Stimulus: i_rsp_rdy=0 with req0 a=5, b=5 accepted, then req1 valid.
  - Response: o_rsp_vld=1, id=0, eq=1, held stable for 3 stall cycles with o_req_rdy=0.
  - Release i_rsp_rdy: in that cycle req1 is granted; next cycle id=1.
- Signed edges, W=8:
  - a=8'hFF, b=8'hFE -> gt=1.
  - a=8'h00, b=8'hFF -> gt=1.
  - a=8'h7F, b=8'h7F -> eq=1.
- Reset mid-operation:
  - Stimulus: FULL with ptr=3, then assert arst for 1 cycle asynchronously.
  - Response: o_rsp_vld drops at once.
  - After release with requesters 1 and 3 valid: requester 1 is granted first (ptr=0).

Source files
------------

// File: rtl/cmp_arb.sv
// rtl/cmp_arb.sv - round-robin arbiter sharing one signed comparator among N requesters
// Grants one valid requester per cycle and registers eq/gt/lt plus its id into a 1-entry output stage.
module cmp_arb #(
  parameter  int N   = 4,
  parameter  int W   = 32,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N-1:0]     i_req_vld,
  input  logic [N*W-1:0]   i_req_a,
  input  logic [N*W-1:0]   i_req_b,
  output logic [N-1:0]     o_req_rdy,
  output logic             o_rsp_vld,
  output logic [IDW-1:0]   o_rsp_id,
  output logic             o_rsp_eq,
  output logic             o_rsp_gt,
  output logic             o_rsp_lt,
  input  logic             i_rsp_rdy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [2*N-1:0] vld_dbl;
  logic [N-1:0]   vld_rot;
  logic           found;
  logic [IDW:0]   off;
  logic [IDW:0]   sum;
  logic [IDW:0]   inc;
  logic [IDW-1:0] gnt;
  logic           accept_ok;
  logic           accept;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           eq_nxt;
  logic           gt_nxt;
  logic           lt_nxt;

  // Rotate the request vector so bit 0 is the requester at ptr; the first set bit is the winner.
  assign vld_dbl = {i_req_vld, i_req_vld} >> ptr;
  assign vld_rot = vld_dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && vld_rot[j]) begin
        found = 1'b1;
        off   = (IDW+1)'(j);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    gnt = sum[IDW-1:0];
    inc = {1'b0, gnt} + (IDW+1)'(1);
    if (inc == N_W) begin
      inc = '0;
    end
    ptr_nxt = inc[IDW-1:0];
  end

  assign accept_ok = (state == EMPTY) | i_rsp_rdy;
  assign accept    = found & accept_ok & ~arst;
  assign o_req_rdy = accept ? (N'(1) << gnt) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == IDW'(k)) begin
        a_sel = i_req_a[k*W +: W];
        b_sel = i_req_b[k*W +: W];
      end
    end
    eq_nxt = (a_sel == b_sel);
    gt_nxt = ($signed(a_sel) > $signed(b_sel));
    lt_nxt = ~eq_nxt & ~gt_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = FULL;
    end else if ((state == FULL) && i_rsp_rdy) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Id, flags and ptr move only on an accept; an idle or stalled cycle leaves priority untouched.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr      <= '0;
      o_rsp_id <= '0;
      o_rsp_eq <= 1'b0;
      o_rsp_gt <= 1'b0;
      o_rsp_lt <= 1'b0;
    end else if (accept) begin
      ptr      <= ptr_nxt;
      o_rsp_id <= gnt;
      o_rsp_eq <= eq_nxt;
      o_rsp_gt <= gt_nxt;
      o_rsp_lt <= lt_nxt;
    end
  end

  assign o_rsp_vld = (state == FULL);

  a_rdy_onehot0: assert property (@(posedge clk) disable iff (arst) $onehot0(o_req_rdy));

  a_rsp_stable: assert property (@(posedge clk) disable iff (arst)
    (o_rsp_vld && !i_rsp_rdy) |=> (o_rsp_vld && $stable(o_rsp_id) && $stable(o_rsp_eq)
                                   && $stable(o_rsp_gt) && $stable(o_rsp_lt)));

  a_flags_onehot: assert property (@(posedge clk) disable iff (arst)
    o_rsp_vld |-> $onehot({o_rsp_eq, o_rsp_gt, o_rsp_lt}));

endmodule
